// File: rtl/ppm_pkg.sv
// Shared definitions for the 8-ary PPM receive path.
//   PPM_ORDER   : number of chip slots per symbol frame
//   SYM_BITS    : width of a decided symbol index
//   ppm_state_e : frame sequencer states
//   sat_inc     : saturating increment, used for the chip counters
package ppm_pkg;

  localparam int unsigned PPM_ORDER = 8;
  localparam int unsigned SYM_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_GUARD,
    ST_EVAL
  } ppm_state_e;

  // Returns val+1, clamped to max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ppm_sym_outreg.sv
// Valid/ready holding register for decided PPM symbols.
//   load          : a new decision is presented this cycle
//   load_*        : decision fields (symbol, peak count, erasure flag)
//   clr_overrun   : clears the sticky overrun flag
//   sym_ready     : downstream accepts the held symbol
//   sym_valid/out/peak/erasure : held symbol
//   overrun_err   : sticky, set when a decision could not be stored
module ppm_sym_outreg
  import ppm_pkg::*;
#(
  parameter int unsigned CHIP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 load,
  input  logic [SYM_BITS-1:0]  load_sym,
  input  logic [CHIP_BITS-1:0] load_peak,
  input  logic                 load_erasure,
  input  logic                 clr_overrun,
  input  logic                 sym_ready,
  output logic                 sym_valid,
  output logic [SYM_BITS-1:0]  sym_out,
  output logic [CHIP_BITS-1:0] sym_peak,
  output logic                 sym_erasure,
  output logic                 overrun_err
);

  logic                 valid_q,   valid_d;
  logic [SYM_BITS-1:0]  sym_q,     sym_d;
  logic [CHIP_BITS-1:0] peak_q,    peak_d;
  logic                 erasure_q, erasure_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    valid_d   = valid_q;
    sym_d     = sym_q;
    peak_d    = peak_q;
    erasure_d = erasure_q;
    overrun_d = overrun_q;

    if (sym_ready) valid_d = 1'b0;

    // A load is accepted when the register is empty or drains on this edge.
    if (load) begin
      if (!valid_q || sym_ready) begin
        valid_d   = 1'b1;
        sym_d     = load_sym;
        peak_d    = load_peak;
        erasure_d = load_erasure;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q   <= 1'b0;
      sym_q     <= '0;
      peak_q    <= '0;
      erasure_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      sym_q     <= sym_d;
      peak_q    <= peak_d;
      erasure_q <= erasure_d;
      overrun_q <= overrun_d;
    end
  end

  assign sym_valid   = valid_q;
  assign sym_out     = sym_q;
  assign sym_peak    = peak_q;
  assign sym_erasure = erasure_q;
  assign overrun_err = overrun_q;

endmodule

// File: rtl/ppm8_chip_sequencer.sv
// Frame sequencer for the 8-ary PPM receive path.
// Bins SPAD pulses into eight chip-slot counters per frame, presents them to
// the external correlator for one EVAL cycle, and captures the decision into
// a valid/ready output register.
//   clk, rstb          : clock, async active-low reset
//   enable             : run frames back-to-back while high
//   spad_pulse         : one detection per high cycle
//   threshold_cfg      : threshold, sampled at frame start
//   chips_out          : chip counters, chip i at [i*CHIP_BITS +: CHIP_BITS]
//   corr_valid/threshold, corr_symbol/peak/unmet : correlator interface
//   sym_valid/ready/out/peak/erasure : decided symbol output
//   overrun_err        : sticky, a decision was dropped (cleared in IDLE)
module ppm8_chip_sequencer
  import ppm_pkg::*;
#(
  parameter int unsigned CHIP_BITS    = 3,
  parameter int unsigned SLOT_CYCLES  = 8,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           enable,
  input  logic                           spad_pulse,
  input  logic [CHIP_BITS-1:0]           threshold_cfg,
  output logic [PPM_ORDER*CHIP_BITS-1:0] chips_out,
  output logic                           corr_valid,
  output logic [CHIP_BITS-1:0]           corr_threshold,
  input  logic [SYM_BITS-1:0]            corr_symbol,
  input  logic [CHIP_BITS-1:0]           corr_peak,
  input  logic                           corr_unmet,
  output logic                           sym_valid,
  input  logic                           sym_ready,
  output logic [SYM_BITS-1:0]            sym_out,
  output logic [CHIP_BITS-1:0]           sym_peak,
  output logic                           sym_erasure,
  output logic                           overrun_err
);

  localparam int unsigned CW = (SLOT_CYCLES  > 1) ? $clog2(SLOT_CYCLES)  : 1;
  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [31:0] CHIP_MAX = (32'd1 << CHIP_BITS) - 32'd1;

  ppm_state_e                           state_q, state_d;
  logic [CW-1:0]                        cyc_cnt_q, cyc_cnt_d;
  logic [SYM_BITS-1:0]                  slot_idx_q, slot_idx_d;
  logic [GW-1:0]                        guard_cnt_q, guard_cnt_d;
  logic [PPM_ORDER-1:0][CHIP_BITS-1:0]  chips_q, chips_d;
  logic [CHIP_BITS-1:0]                 thr_q, thr_d;
  logic                                 corr_valid_q, corr_valid_d;
  logic                                 start_frame;

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    slot_idx_d  = slot_idx_q;
    guard_cnt_d = guard_cnt_q;
    chips_d     = chips_q;
    thr_d       = thr_q;
    start_frame = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      ST_ACQ: begin
        if (!enable) begin
          state_d = ST_IDLE;
          chips_d = '0;
        end else begin
          if (spad_pulse)
            chips_d[slot_idx_q] = CHIP_BITS'(sat_inc(32'(chips_q[slot_idx_q]), CHIP_MAX));
          if (cyc_cnt_q == CW'(SLOT_CYCLES - 1)) begin
            cyc_cnt_d = '0;
            if (slot_idx_q == SYM_BITS'(PPM_ORDER - 1)) begin
              slot_idx_d = '0;
              if (GUARD_CYCLES == 0) begin
                state_d = ST_EVAL;
              end else begin
                state_d     = ST_GUARD;
                guard_cnt_d = '0;
              end
            end else begin
              slot_idx_d = slot_idx_q + 1'b1;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (!enable) begin
          state_d = ST_IDLE;
          chips_d = '0;
        end else if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = ST_EVAL;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        // Evaluation always completes; enable only picks the next state.
        if (enable) start_frame = 1'b1;
        else        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d    = ST_ACQ;
      chips_d    = '0;
      cyc_cnt_d  = '0;
      slot_idx_d = '0;
      thr_d      = threshold_cfg;
    end

    corr_valid_d = (state_d == ST_EVAL);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      cyc_cnt_q    <= '0;
      slot_idx_q   <= '0;
      guard_cnt_q  <= '0;
      chips_q      <= '0;
      thr_q        <= '0;
      corr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      slot_idx_q   <= slot_idx_d;
      guard_cnt_q  <= guard_cnt_d;
      chips_q      <= chips_d;
      thr_q        <= thr_d;
      corr_valid_q <= corr_valid_d;
    end
  end

  assign chips_out      = chips_q;
  assign corr_valid     = corr_valid_q;
  assign corr_threshold = thr_q;

  ppm_sym_outreg #(
    .CHIP_BITS (CHIP_BITS)
  ) u_outreg (
    .clk          (clk),
    .rstb         (rstb),
    .load         (state_q == ST_EVAL),
    .load_sym     (corr_symbol),
    .load_peak    (corr_peak),
    .load_erasure (corr_unmet),
    .clr_overrun  (state_q == ST_IDLE),
    .sym_ready    (sym_ready),
    .sym_valid    (sym_valid),
    .sym_out      (sym_out),
    .sym_peak     (sym_peak),
    .sym_erasure  (sym_erasure),
    .overrun_err  (overrun_err)
  );

endmodule

// File: tb/tb_ppm8_chip_sequencer.sv
module tb_ppm8_chip_sequencer;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        enable = 1'b0;
  logic        spad_pulse = 1'b0;
  logic [2:0]  threshold_cfg = '0;
  logic [23:0] chips_out;
  logic        corr_valid;
  logic [2:0]  corr_threshold;
  logic [2:0]  corr_symbol;
  logic [2:0]  corr_peak;
  logic        corr_unmet;
  logic        sym_valid;
  logic        sym_ready = 1'b0;
  logic [2:0]  sym_out;
  logic [2:0]  sym_peak;
  logic        sym_erasure;
  logic        overrun_err;

  typedef struct {
    logic [2:0] sym;
    logic [2:0] peak;
    logic       er;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ppm8_chip_sequencer #(
    .CHIP_BITS    (3),
    .SLOT_CYCLES  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .enable         (enable),
    .spad_pulse     (spad_pulse),
    .threshold_cfg  (threshold_cfg),
    .chips_out      (chips_out),
    .corr_valid     (corr_valid),
    .corr_threshold (corr_threshold),
    .corr_symbol    (corr_symbol),
    .corr_peak      (corr_peak),
    .corr_unmet     (corr_unmet),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .sym_out        (sym_out),
    .sym_peak       (sym_peak),
    .sym_erasure    (sym_erasure),
    .overrun_err    (overrun_err)
  );

  // Behavioral correlator stub: max chip, lowest index wins ties.
  always_comb begin
    corr_symbol = '0;
    corr_peak   = '0;
    for (int i = 0; i < 8; i++) begin
      if (chips_out[i*3 +: 3] > corr_peak) begin
        corr_peak   = chips_out[i*3 +: 3];
        corr_symbol = 3'(i);
      end
    end
    corr_unmet = (corr_peak < corr_threshold);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard drain: compare every symbol handed downstream.
  always @(negedge clk) begin
    if (rstb && sym_valid && sym_ready) begin
      check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_sym",     32'(sym_out),     32'(e.sym));
        check_eq("sb_peak",    32'(sym_peak),    32'(e.peak));
        check_eq("sb_erasure", 32'(sym_erasure), 32'(e.er));
      end
    end
  end

  // Slot counts packed as nibbles; n pulses at the start of each slot.
  function automatic logic [63:0] mk_mask(input logic [31:0] cnts);
    logic [63:0] m;
    m = '0;
    for (int s = 0; s < 8; s++)
      for (int p = 0; p < 8; p++)
        if (p < int'(cnts[s*4 +: 4])) m[s*8 + p] = 1'b1;
    return m;
  endfunction

  // Entered in the cycle before frame cycle 0 (enable already high).
  // stop_at >= 0 returns right after driving that frame cycle.
  task automatic run_frame(input logic [63:0] mask, input logic [2:0] thr, input int stop_at);
    int          cv_seen;
    int          n;
    int          pk;
    int          sy;
    logic [23:0] exp_chips;
    exp_t        e;
    cv_seen = 0;
    threshold_cfg = thr;
    for (int c = 0; c < 66; c++) begin
      @(posedge clk); #1;
      spad_pulse = (c < 64) ? mask[c] : 1'b1;
      if (c == 30) threshold_cfg = thr ^ 3'b101;
      if (c == stop_at) return;
      @(negedge clk);
      if (corr_valid) cv_seen++;
    end
    @(posedge clk); #1;
    spad_pulse = 1'b1;
    @(negedge clk);
    pk = 0;
    sy = 0;
    exp_chips = '0;
    for (int s = 0; s < 8; s++) begin
      n = 0;
      for (int p = 0; p < 8; p++) n += int'(mask[s*8 + p]);
      if (n > 7) n = 7;
      exp_chips[s*3 +: 3] = 3'(n);
      if (n > pk) begin
        pk = n;
        sy = s;
      end
    end
    check_eq("eval_corr_valid", 32'(corr_valid), 32'd1);
    check_eq("early_corr_valid", 32'(cv_seen), 32'd0);
    check_eq("eval_chips", 32'(chips_out), 32'(exp_chips));
    check_eq("eval_threshold", 32'(corr_threshold), 32'(thr));
    e.sym  = 3'(sy);
    e.peak = 3'(pk);
    e.er   = (pk < int'(thr));
    if (sb_q.size() == 0 || sym_ready) sb_q.push_back(e);
  endtask

  initial begin
    int cv_cnt;

    // Reset state
    #1 rstb = 1'b0;
    #2;
    check_eq("rst_chips", 32'(chips_out), 32'd0);
    check_eq("rst_thr", 32'(corr_threshold), 32'd0);
    check_eq("rst_corr_valid", 32'(corr_valid), 32'd0);
    check_eq("rst_sym_valid", 32'(sym_valid), 32'd0);
    check_eq("rst_overrun", 32'(overrun_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;

    // 1: basic frame, decision held with ready low
    enable = 1'b1;
    run_frame(mk_mask(32'h0000_6321), 3'd4, -1);
    check_eq("t1_valid_at_eval", 32'(sym_valid), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check_eq("t1_sym_valid", 32'(sym_valid), 32'd1);
    check_eq("t1_sym_out", 32'(sym_out), 32'd3);
    check_eq("t1_sym_peak", 32'(sym_peak), 32'd6);
    check_eq("t1_erasure", 32'(sym_erasure), 32'd0);
    @(posedge clk); #1;
    sym_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 2/3 + boundaries: back-to-back frames
    enable = 1'b1;
    run_frame(mk_mask(32'h0080_0000), 3'd3, -1);
    run_frame(64'h8000_0000_0180_0001, 3'd1, -1);
    run_frame(mk_mask(32'h0000_0005), 3'd7, -1);
    run_frame({$urandom, $urandom}, 3'($urandom_range(0, 7)), -1);
    enable = 1'b0;
    repeat (4) @(posedge clk); #1;

    // 4: overrun
    sym_ready = 1'b0;
    enable = 1'b1;
    run_frame(mk_mask(32'h0000_0300), 3'd1, -1);
    run_frame(mk_mask(32'h0400_0000), 3'd1, -1);
    check_eq("t4_held_sym", 32'(sym_out), 32'd2);
    enable = 1'b0;
    @(negedge clk);
    check_eq("t4_overrun_set", 32'(overrun_err), 32'd1);
    check_eq("t4_held_after", 32'(sym_out), 32'd2);
    check_eq("t4_held_peak", 32'(sym_peak), 32'd3);
    check_eq("t4_held_valid", 32'(sym_valid), 32'd1);
    @(negedge clk);
    check_eq("t4_overrun_clr", 32'(overrun_err), 32'd0);
    @(posedge clk); #1;
    sym_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 5: abort in slot 4
    enable = 1'b1;
    run_frame(mk_mask(32'h2222_2222), 3'd2, 35);
    enable = 1'b0;
    spad_pulse = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_chips_cleared", 32'(chips_out), 32'd0);
    cv_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (corr_valid) cv_cnt++;
    end
    check_eq("t5_no_corr_valid", 32'(cv_cnt), 32'd0);
    check_eq("t5_no_symbol", 32'(sym_valid), 32'd0);
    @(posedge clk); #1;

    // 6: async reset in GUARD, then a clean frame
    sym_ready = 1'b0;
    enable = 1'b1;
    run_frame(mk_mask(32'h0005_0000), 3'd5, -1);
    run_frame(mk_mask(32'h0000_0070), 3'd5, 64);
    #2 rstb = 1'b0;
    #1;
    check_eq("t6_chips", 32'(chips_out), 32'd0);
    check_eq("t6_thr", 32'(corr_threshold), 32'd0);
    check_eq("t6_corr_valid", 32'(corr_valid), 32'd0);
    check_eq("t6_sym_valid", 32'(sym_valid), 32'd0);
    check_eq("t6_sym_out", 32'(sym_out), 32'd0);
    check_eq("t6_sym_peak", 32'(sym_peak), 32'd0);
    check_eq("t6_erasure", 32'(sym_erasure), 32'd0);
    check_eq("t6_overrun", 32'(overrun_err), 32'd0);
    sb_q.delete();
    spad_pulse = 1'b0;
    sym_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    run_frame(mk_mask(32'h1000_0042), 3'd2, -1);
    enable = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ppm8_chip_sequencer.md
# ppm8_chip_sequencer

Frame sequencer for the 8-ary PPM receive path. Bins single-cycle SPAD detection pulses into eight chip-slot counters over one symbol frame. Presents the counts to the combinational `ppm8_correlator` for a single evaluation cycle, then captures the decision into a valid/ready output register. It sits between the SPAD pulse synchronizer and the symbol deframer, and owns all timing and configuration of the correlator.

## Interface
- `CHIP_BITS`, 3: width of each chip count and of the threshold.
- `SLOT_CYCLES`, 8: clock cycles per chip slot, ≥1.
- `GUARD_CYCLES`, 2: dead cycles after slot 7 (inter-symbol guard), ≥0.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstb`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  run frames continuously while high.
- `spad_pulse`  in  1  one detection per high cycle; already synchronized.
- `threshold_cfg`  in  CHIP_BITS  correlation threshold; sampled at frame start.
- `chips_out`  out  8*CHIP_BITS  to correlator `chips_in`; chip i at `[i*CHIP_BITS +: CHIP_BITS]`.
- `corr_valid`  out  1  to correlator `input_valid`.
- `corr_threshold`  out  CHIP_BITS  to correlator `corr_threshold`.
- `corr_symbol`  in  3  from correlator `symbol`.
- `corr_peak`  in  CHIP_BITS  from correlator `peak_value`.
- `corr_unmet`  in  1  from correlator `threshold_unmet`.
- `sym_valid`  out  1  output symbol available.
- `sym_ready`  in  1  downstream accepts.
- `sym_out`  out  3  decided symbol.
- `sym_peak`  out  CHIP_BITS  peak count of the decision.
- `sym_erasure`  out  1  peak below threshold; symbol is an erasure.
- `overrun_err`  out  1  sticky: a decision was dropped.

## Operation
States: IDLE, ACQ, GUARD, EVAL.

- **IDLE:** when `enable`=1, go to ACQ. On that edge: clear all chips to 0, clear `slot_idx` and `cyc_cnt`, latch `threshold_cfg` into `corr_threshold`.
- **ACQ:**
  - `cyc_cnt` counts 0..SLOT_CYCLES-1. It wraps to 0 and increments `slot_idx` (0..7).
  - `spad_pulse`=1 increments `chip[slot_idx]`, saturating at 2^CHIP_BITS-1.
  - After the last cycle of slot 7, go to GUARD, or to EVAL if GUARD_CYCLES=0.
- **GUARD:** GUARD_CYCLES cycles. Pulses ignored. Chips held. Then go to EVAL.
- **EVAL:** exactly one cycle.
  - `corr_valid`=1. `chips_out` and `corr_threshold` are stable.
  - Correlator results are sampled at the end of this cycle.
  - Pulses ignored.
  - Next state is ACQ (with the IDLE→ACQ clear and latch actions) if `enable`=1, else IDLE.
- **Output register:**
  - EVAL loads `sym_out`/`sym_peak`/`sym_erasure` and sets `sym_valid` if the register is empty, or is being drained in the same cycle (`sym_valid & sym_ready`).
  - Otherwise the new decision is dropped, the held symbol is unchanged, and `overrun_err` is set.
  - `sym_valid` clears on `sym_ready` when there is no simultaneous load.
- **`overrun_err`:** clears only in IDLE.
- **`enable` low:**
  - During ACQ or GUARD: abort to IDLE next edge, chips cleared, no EVAL.
  - During EVAL: the evaluation completes.
  - A pending output symbol is unaffected.
- **Outputs outside EVAL:** `chips_out` is always the live counter registers; `corr_valid`=0.

## Timing
- Reset (async assert, synchronous-release): state IDLE. All outputs 0, including `chips_out`, `corr_threshold`, `sym_*` and `overrun_err`.
- Frame length is 8*SLOT_CYCLES + GUARD_CYCLES + 1 cycles. Frames are back-to-back while enabled.
- Counting frame cycles from the first ACQ cycle = 0: EVAL occurs at cycle 8*SLOT_CYCLES + GUARD_CYCLES.
- `sym_valid` rises on the cycle after EVAL.
- A pulse in the last ACQ cycle of slot k counts to chip k. A pulse in the first ACQ cycle counts to the next slot.

## Structure
- Shared `ppm_pkg`: state enum, `PPM_ORDER`=8, a `SYM_BITS`=3 constant, and a saturating-increment function.
- One natural sub-module: `ppm_sym_outreg`, the valid/ready holding register with overrun detection.
- The correlator is not instantiated inside this block; it is wired alongside at the top level.

## Test plan
All scenarios use CHIP_BITS=3, SLOT_CYCLES=8, GUARD_CYCLES=2, and a behavioral correlator stub.

1. Slot pulses 1,2,3,6,0,0,0,0 → `chips_out`={0,0,0,0,6,3,2,1}; `corr_valid` high only at frame cycle 66. With the stub returning symbol 3, peak 6 → cycle 67 shows `sym_valid`=1, `sym_out`=3, `sym_peak`=6.
2. 8 pulses in slot 5 → chip5=7 (saturated, no wrap); other chips 0.
3. `threshold_cfg`=7 and stub `corr_unmet`=1 → `sym_erasure`=1. Changing `threshold_cfg` mid-frame leaves `corr_threshold` unchanged.
4. `sym_ready`=0 across two frames → first symbol held stable, second dropped, `overrun_err`=1. Drop `enable` → `overrun_err` clears in IDLE.
5. `enable` dropped in slot 4 → IDLE next cycle; `chips_out`=0; no `corr_valid` pulse.
6. `rstb` asserted mid-GUARD → all outputs 0 without waiting for `clk`. After release with `enable`=1, a full frame completes normally.
